// File: rtl/reg_writeback_pkg.sv
// Shared widths and the buffered-write record for the register-file write driver.
package reg_writeback_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_SEL_W  = 4;
  localparam int DEF_DEPTH  = 2;

  typedef struct packed {
    logic [DEF_SEL_W-1:0]  sel;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Producer handshakes, regfile write port and operand-fetch pending query.
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
);

  logic              alu_valid;
  logic              alu_ready;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [SEL_W-1:0]  mem_sel;
  logic [DATA_W-1:0] mem_data;
  logic [SEL_W-1:0]  reg_in_sel;
  logic [DATA_W-1:0] reg_in;
  logic              reg_in_we;
  logic [SEL_W-1:0]  query_sel0;
  logic [SEL_W-1:0]  query_sel1;
  logic              pending0;
  logic              pending1;

  modport master (
    output alu_valid, alu_sel, alu_data, mem_valid, mem_sel, mem_data,
    output query_sel0, query_sel1,
    input  alu_ready, mem_ready, reg_in_sel, reg_in, reg_in_we, pending0, pending1
  );

  modport slave (
    input  alu_valid, alu_sel, alu_data, mem_valid, mem_sel, mem_data,
    input  query_sel0, query_sel1,
    output alu_ready, mem_ready, reg_in_sel, reg_in, reg_in_we, pending0, pending1
  );

endinterface

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: circular buffer of load results with per-slot occupancy exposed
// so the caller can match destination registers against buffered writes.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic                              pop,
  input  wb_entry_t                         push_entry,
  output wb_entry_t                         head,
  output logic                              full,
  output logic                              empty,
  output logic [CNT_W-1:0]                  count,
  output logic [DEPTH-1:0]                  ent_valid,
  output logic [DEPTH-1:0][DEF_SEL_W-1:0]   ent_sel
);

  wb_entry_t        slot_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [DEPTH-1:0] occ_r;
  logic [DEPTH-1:0] occ_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign head      = slot_r[rd_ptr_r];
  assign ent_valid = occ_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next occupancy per slot and slot destination view.
  always_comb begin
    occ_s   = occ_r;
    ent_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_s[i]   = (occ_r[i] && !(do_pop_s && (rd_ptr_r == PTR_W'(i))))
                 || (do_push_s && (wr_ptr_r == PTR_W'(i)));
      ent_sel[i] = slot_r[i].sel;
    end
  end

  // Slot payload storage; occupancy tracks validity, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      slot_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers, count and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      occ_r    <= '0;
    end else begin
      occ_r <= occ_s;
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write driver: arbitrates ALU and buffered load results onto
// the single registered write port and flags registers with writes in flight.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  reg_writeback_if.slave wb
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t                        head_s;
  wb_entry_t                        push_entry_s;
  wb_entry_t                        issue_entry_s;
  logic                             full_s;
  logic                             empty_s;
  logic [CNT_W-1:0]                 count_s;
  logic [DEPTH-1:0]                 ent_valid_s;
  logic [DEPTH-1:0][DEF_SEL_W-1:0]  ent_sel_s;
  logic                             push_s;
  logic                             pop_s;
  logic                             issue_s;
  logic                             alu_ready_s;
  logic                             mem_ready_s;
  logic                             alu_fire_s;
  logic                             out_we_r;
  logic [SEL_W-1:0]                 out_sel_r;
  logic [DATA_W-1:0]                out_data_r;

  function automatic logic buffered(input logic [DEPTH-1:0] valid,
                                    input logic [DEPTH-1:0][DEF_SEL_W-1:0] sels,
                                    input logic [SEL_W-1:0] q);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit = hit | (valid[i] && (sels[i] == q));
    end
    return hit;
  endfunction

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .push_entry (push_entry_s),
    .head       (head_s),
    .full       (full_s),
    .empty      (empty_s),
    .count      (count_s),
    .ent_valid  (ent_valid_s),
    .ent_sel    (ent_sel_s)
  );

  // A younger ALU write never overtakes a buffered load to the same register.
  assign mem_ready_s  = (count_s != CNT_W'(DEPTH));
  assign alu_ready_s  = !full_s && !buffered(ent_valid_s, ent_sel_s, wb.alu_sel);
  assign alu_fire_s   = wb.alu_valid && alu_ready_s;
  assign push_s       = wb.mem_valid && mem_ready_s;
  assign push_entry_s = '{sel: wb.mem_sel, data: wb.mem_data};

  // Issue arbitration: full FIFO first, then ALU, then any buffered load.
  always_comb begin
    issue_s       = 1'b0;
    pop_s         = 1'b0;
    issue_entry_s = '0;
    if (full_s) begin
      issue_s       = 1'b1;
      pop_s         = 1'b1;
      issue_entry_s = head_s;
    end else if (alu_fire_s) begin
      issue_s       = 1'b1;
      issue_entry_s = '{sel: wb.alu_sel, data: wb.alu_data};
    end else if (!empty_s) begin
      issue_s       = 1'b1;
      pop_s         = 1'b1;
      issue_entry_s = head_s;
    end else begin
      issue_s       = 1'b0;
      pop_s         = 1'b0;
    end
  end

  // Registered regfile write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_we_r   <= 1'b0;
      out_sel_r  <= '0;
      out_data_r <= '0;
    end else begin
      out_we_r <= issue_s;
      if (issue_s) begin
        out_sel_r  <= issue_entry_s.sel;
        out_data_r <= issue_entry_s.data;
      end
    end
  end

  assign wb.alu_ready  = alu_ready_s;
  assign wb.mem_ready  = mem_ready_s;
  assign wb.reg_in_we  = out_we_r;
  assign wb.reg_in_sel = out_sel_r;
  assign wb.reg_in     = out_data_r;
  assign wb.pending0   = buffered(ent_valid_s, ent_sel_s, wb.query_sel0)
                       || (out_we_r && (out_sel_r == wb.query_sel0));
  assign wb.pending1   = buffered(ent_valid_s, ent_sel_s, wb.query_sel1)
                       || (out_we_r && (out_sel_r == wb.query_sel1));

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: cycle vector table plus WAW and mid-operation
// reset sequences, with a write-order scoreboard fed by accepted handshakes.
module tb_reg_writeback;

  typedef struct {
    logic        av; logic [3:0] as; logic [15:0] ad;
    logic        mv; logic [3:0] ms; logic [15:0] md;
    logic [3:0]  q0; logic [3:0] q1;
    logic        ar; logic mr; logic we; logic [3:0] ws; logic [15:0] wd;
    logic        p0; logic p1; logic cd;
  } vec_t;

  localparam int NV = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_writeback_if wb ();
  reg_writeback dut (.clk(clk), .rst(rst), .wb(wb.slave));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [19:0] alu_q [$];
  logic [19:0] mem_q [$];
  vec_t        vec [NV];

  function automatic vec_t mk(logic av, logic [3:0] as, logic [15:0] ad,
                              logic mv, logic [3:0] ms, logic [15:0] md,
                              logic [3:0] q0, logic [3:0] q1,
                              logic ar, logic mr, logic we, logic [3:0] ws,
                              logic [15:0] wd, logic p0, logic p1, logic cd);
    vec_t v;
    v.av = av; v.as = as; v.ad = ad; v.mv = mv; v.ms = ms; v.md = md;
    v.q0 = q0; v.q1 = q1; v.ar = ar; v.mr = mr; v.we = we; v.ws = ws;
    v.wd = wd; v.p0 = p0; v.p1 = p1; v.cd = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] as, input logic [15:0] ad,
                       input logic mv, input logic [3:0] ms, input logic [15:0] md,
                       input logic [3:0] q0, input logic [3:0] q1);
    wb.alu_valid = av; wb.alu_sel = as; wb.alu_data = ad;
    wb.mem_valid = mv; wb.mem_sel = ms; wb.mem_data = md;
    wb.query_sel0 = q0; wb.query_sel1 = q1;
  endtask

  // Record handshakes of the closing cycle, advance one edge, score any write.
  task automatic next_cycle();
    if (rst) begin
      alu_q.delete();
      mem_q.delete();
    end else begin
      if (wb.alu_valid && wb.alu_ready) alu_q.push_back({wb.alu_sel, wb.alu_data});
      if (wb.mem_valid && wb.mem_ready) mem_q.push_back({wb.mem_sel, wb.mem_data});
    end
    @(posedge clk);
    #1;
    if (wb.reg_in_we === 1'b1) begin
      n_cmp++;
      if (alu_q.size() > 0 && alu_q[0] == {wb.reg_in_sel, wb.reg_in}) begin
        void'(alu_q.pop_front());
      end else if (mem_q.size() > 0 && mem_q[0] == {wb.reg_in_sel, wb.reg_in}) begin
        void'(mem_q.pop_front());
      end else begin
        n_bad++;
        $display("FAIL sb_write: got sel %0d data 0x%h, required oldest accepted ALU or load result",
                 wb.reg_in_sel, wb.reg_in);
      end
    end
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [3:0] ws, input logic [15:0] wd);
    chk({tag, "_we"}, wb.reg_in_we, we);
    chk({tag, "_sel"}, wb.reg_in_sel, ws);
    chk({tag, "_data"}, wb.reg_in, wd);
  endtask

  initial begin
    //          av as  ad        mv ms  md        q0 q1 ar mr we ws  wd        p0 p1 cd
    vec[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 3, 7, 1, 1, 0, 0, 16'h0000, 0, 0, 1);
    vec[1]  = mk(1, 3, 16'h1234, 0, 0, 16'h0000, 3, 7, 1, 1, 0, 0, 16'h0000, 0, 0, 0);
    vec[2]  = mk(0, 0, 16'h0000, 1, 7, 16'hBEEF, 3, 7, 1, 1, 1, 3, 16'h1234, 1, 0, 1);
    vec[3]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 3, 7, 1, 1, 0, 0, 16'h0000, 0, 1, 0);
    vec[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 3, 7, 1, 1, 1, 7, 16'hBEEF, 0, 1, 1);
    vec[5]  = mk(1, 1, 16'hA001, 1, 2, 16'hB002, 2, 1, 1, 1, 0, 0, 16'h0000, 0, 0, 0);
    vec[6]  = mk(1, 1, 16'hA002, 1, 4, 16'hB004, 2, 1, 1, 1, 1, 1, 16'hA001, 1, 1, 1);
    vec[7]  = mk(1, 1, 16'hA003, 1, 6, 16'hB006, 2, 4, 0, 0, 1, 1, 16'hA002, 1, 1, 1);
    vec[8]  = mk(1, 1, 16'hA003, 1, 6, 16'hB006, 2, 6, 1, 1, 1, 2, 16'hB002, 1, 0, 1);
    vec[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 4, 6, 0, 0, 1, 1, 16'hA003, 1, 1, 1);
    vec[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 4, 6, 1, 1, 1, 4, 16'hB004, 1, 1, 1);
    vec[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 4, 6, 1, 1, 1, 6, 16'hB006, 0, 1, 1);
    vec[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 4, 6, 1, 1, 0, 0, 16'h0000, 0, 0, 0);
    vec[13] = mk(1, 0, 16'h5A5A, 0, 0, 16'h0000, 0, 6, 1, 1, 0, 0, 16'h0000, 0, 0, 0);
    vec[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 6, 1, 1, 1, 0, 16'h5A5A, 1, 0, 1);
    vec[15] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 6, 1, 1, 0, 0, 16'h0000, 0, 0, 0);

    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      next_cycle();
      drive(vec[i].av, vec[i].as, vec[i].ad, vec[i].mv, vec[i].ms, vec[i].md, vec[i].q0, vec[i].q1);
      #1;
      chk($sformatf("v%0d_alu_ready", i), wb.alu_ready, vec[i].ar);
      chk($sformatf("v%0d_mem_ready", i), wb.mem_ready, vec[i].mr);
      chk($sformatf("v%0d_we", i), wb.reg_in_we, vec[i].we);
      chk($sformatf("v%0d_pending0", i), wb.pending0, vec[i].p0);
      chk($sformatf("v%0d_pending1", i), wb.pending1, vec[i].p1);
      if (vec[i].cd) begin
        chk($sformatf("v%0d_sel", i), wb.reg_in_sel, vec[i].ws);
        chk($sformatf("v%0d_data", i), wb.reg_in, vec[i].wd);
      end
    end

    // WAW: load to r5 buffered behind an ALU write, then ALU offers r5.
    next_cycle();
    drive(1, 9, 16'hD009, 1, 5, 16'hC005, 5, 9);
    #1;
    chk("waw_a_alu_ready", wb.alu_ready, 1'b1);
    next_cycle();
    drive(0, 5, 16'hD005, 0, 0, 16'h0000, 5, 9);
    #1;
    chk("waw_b_ready_idle", wb.alu_ready, 1'b0);
    chk("waw_b_pending5", wb.pending0, 1'b1);
    wb.alu_valid = 1'b1;
    #1;
    chk("waw_b_ready_valid", wb.alu_ready, 1'b0);
    chk_port("waw_b", 1'b1, 4'd9, 16'hD009);
    next_cycle();
    drive(1, 5, 16'hD005, 0, 0, 16'h0000, 5, 9);
    #1;
    chk("waw_c_alu_ready", wb.alu_ready, 1'b1);
    chk_port("waw_c", 1'b1, 4'd5, 16'hC005);
    next_cycle();
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 5, 9);
    #1;
    chk_port("waw_d", 1'b1, 4'd5, 16'hD005);
    next_cycle();
    #1;
    chk("waw_e_we", wb.reg_in_we, 1'b0);

    // Reset with two loads buffered and an ALU write on the port.
    next_cycle();
    drive(1, 8, 16'hE008, 1, 11, 16'hE00B, 11, 12);
    #1;
    chk("rst_a_alu_ready", wb.alu_ready, 1'b1);
    chk("rst_a_mem_ready", wb.mem_ready, 1'b1);
    next_cycle();
    drive(1, 8, 16'hE018, 1, 12, 16'hE00C, 11, 12);
    #1;
    chk("rst_b_mem_ready", wb.mem_ready, 1'b1);
    chk_port("rst_b", 1'b1, 4'd8, 16'hE008);
    next_cycle();
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 11, 12);
    rst = 1'b1;
    #1;
    chk("rst_c_mem_ready_full", wb.mem_ready, 1'b0);
    chk("rst_c_pending0", wb.pending0, 1'b1);
    chk("rst_c_pending1", wb.pending1, 1'b1);
    next_cycle();
    rst = 1'b0;
    #1;
    chk_port("rst_d", 1'b0, 4'd0, 16'h0000);
    chk("rst_d_alu_ready", wb.alu_ready, 1'b1);
    chk("rst_d_mem_ready", wb.mem_ready, 1'b1);
    chk("rst_d_pending0", wb.pending0, 1'b0);
    chk("rst_d_pending1", wb.pending1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      chk($sformatf("rst_idle%0d_we", k), wb.reg_in_we, 1'b0);
    end

    chk("sb_alu_left", alu_q.size(), 32'd0);
    chk("sb_mem_left", mem_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side driver for the 16 x 16-bit register file. Accepts results from two producers, the ALU and the memory load unit, through valid/ready handshakes. Buffers load results in a small FIFO, serialises everything onto the regfile's single write port (select, data, write-enable), and reports which registers still have writes in flight so operand fetch can stall. Sits between execute/memory and the regfile write port.

## Interface
Parameters:
- DATA_W, 16, register width
- SEL_W, 4, register select width
- DEPTH, 2, load-result FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when valid & ready
- alu_sel  in  SEL_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted when valid & ready
- mem_sel  in  SEL_W  load destination
- mem_data  in  DATA_W  load data
- reg_in_sel  out  SEL_W  regfile write select (registered)
- reg_in  out  DATA_W  regfile write data (registered)
- reg_in_we  out  1  regfile write enable (registered)
- query_sel0, query_sel1  in  SEL_W  registers operand fetch wants to read
- pending0, pending1  out  1  queried register has an uncommitted write

## Operation
- Load FIFO: DEPTH entries of {sel, data}; push on mem_valid & mem_ready; mem_ready = !full, combinational from registered count only.
- Each cycle at most one write issues into the output stage. Priority:
  1. FIFO head if FIFO full.
  2. Else accepted ALU result.
  3. Else FIFO head if non-empty.
  4. Else nothing; reg_in_we = 0.
- alu_ready = !full && !(alu_sel matches any valid FIFO entry's sel). The WAW block means an older load to the same register always commits before a younger ALU write.
- alu_ready deasserts on the WAW match regardless of alu_valid.
- Same-cycle FIFO pop and push when not full is allowed; count is unchanged.
- pendingN = queried sel matches a valid FIFO entry, or the output stage (reg_in_we & reg_in_sel == query_selN). Purely combinational from registered state.
- No register is special; writes to register 0 proceed normally.

## Timing
- Reset: FIFO empty, count 0, reg_in_we = 0, reg_in_sel = 0, reg_in = 0.
  - After reset: mem_ready = 1, alu_ready = 1, pending0/1 = 0.
- Reset mid-operation discards all buffered and in-flight writes; no partial write issues in the reset cycle or the cycle after.
- Latency:
  - ALU accepted at edge N: reg_in_we high in cycle N+1; regfile updated at edge N+2.
  - Load entering an empty FIFO with no ALU traffic: pushed at edge N, popped to the output stage at edge N+1, reg_in_we high in cycle N+2.
- reg_in_we is high for exactly one cycle per write; back-to-back writes give continuous reg_in_we.
- Throughput: one write per cycle sustained.

## Structure
- Shared package: DATA_W, SEL_W, DEPTH defaults, and a wb_entry_t struct {sel, data}.
- One sub-module: wb_fifo, DEPTH-entry circular buffer.
  - Exposes head, full, empty, count.
  - Exposes a per-entry valid/sel vector for the match logic.
- Arbitration, output register and pending logic stay in reg_writeback.

## Test plan
- ALU alone: rst released, alu_valid with sel 3, data 0x1234 at edge 5 -> reg_in_we = 1, reg_in_sel = 3, reg_in = 0x1234 in cycle 6 only; pending with query 3 high in cycle 6.
- Load alone: mem sel 7, data 0xBEEF at edge 5 -> write in cycle 7; pending(7) high in cycles 6-7, low in cycle 8.
- Contention: ALU sel 1 every cycle while loads to sel 2 and 4 arrive -> ALU wins until the FIFO is full. Then alu_ready = 0 for one cycle and the load drains. No write is lost; total reg_in_we count equals accepts.
- WAW: load to sel 5 buffered, ALU offers sel 5 -> alu_ready = 0 until the load issues. Write order on the port is load data, then ALU data.
- Full/empty: 2 loads while ALU is busy -> mem_ready = 0 when count = 2; push refused. Drain -> mem_ready = 1 the cycle after count drops.
- Reset mid-op: FIFO holding 2 entries, rst high for one cycle -> no reg_in_we in the following cycles, count 0, pending0/1 = 0.
